// File: rtl/cpu12_pkg.sv
// cpu12_pkg: shared constants and the write-back entry type for the 12-bit CPU.
//   DATA_W    result / register width
//   REG_AW    register address width
//   NUM_REGS  number of architectural registers
//   WB_DEPTH  default write-back buffer depth
//   WB_PEND_W default per-register outstanding counter width
//   wb_entry_t {dst, data} one buffered register write
package cpu12_pkg;
    localparam int DATA_W    = 12;
    localparam int REG_AW    = 3;
    localparam int NUM_REGS  = 1 << REG_AW;
    localparam int WB_DEPTH  = 4;
    localparam int WB_PEND_W = 4;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_writeback_if.sv
// reg_writeback_if: bundles the write-back controller's producer, decode and
// register-file signals.
//   master : execute/memory/decode side (drives valids, data, issue, operand selects)
//   slave  : reg_writeback (drives readies, busy, forwarding and rf_* write port)
interface reg_writeback_if;
    import cpu12_pkg::*;

    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_dst;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_dst;
    logic [REG_AW-1:0] chk1_sel;
    logic [REG_AW-1:0] chk2_sel;
    logic              busy1;
    logic              busy2;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_sel;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
               issue_valid, issue_dst, chk1_sel, chk2_sel,
        input  mem_ready, alu_ready, busy1, busy2, fwd1_hit, fwd1_data,
               fwd2_hit, fwd2_data, rf_we, rf_sel, rf_wdata
    );

    modport slave (
        input  mem_valid, mem_dst, mem_data, alu_valid, alu_dst, alu_data,
               issue_valid, issue_dst, chk1_sel, chk2_sel,
        output mem_ready, alu_ready, busy1, busy2, fwd1_hit, fwd1_data,
               fwd2_hit, fwd2_data, rf_we, rf_sel, rf_wdata
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: in-order result buffer, two ordered pushes and one pop per cycle.
//   clk, rst_n      clock, synchronous active-low reset
//   push_a / din_a  older push (written first)
//   push_b / din_b  younger push (written after din_a when both fire)
//   pop             remove head
//   head            oldest entry
//   count           occupancy before this cycle's push/pop
//   ents/ents_vld   entries oldest-first with valid flags (only with WB_BYPASS_EN)
// Callers guarantee pushes never exceed free space; no overflow checks here.
module wb_fifo
    import cpu12_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_a,
    input  wb_entry_t     din_a,
    input  logic          push_b,
    input  wb_entry_t     din_b,
    input  logic          pop,
    output wb_entry_t     head,
    output logic [CW-1:0] count
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t [DEPTH-1:0] ents,
    output logic      [DEPTH-1:0] ents_vld
`endif
);
    wb_entry_t     mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, wr_b_ptr;

    // Younger push lands behind the older one when both fire.
    assign wr_b_ptr = push_a ? wr_ptr + AW'(1) : wr_ptr;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr]   <= din_a;
        if (push_b) mem[wr_b_ptr] <= din_b;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
        end
    end

`ifdef WB_BYPASS_EN
    for (genvar i = 0; i < DEPTH; i++) begin : g_ents
        assign ents[i]     = mem[rd_ptr + AW'(i)];
        assign ents_vld[i] = (CW'(i) < count);
    end
`endif
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: write-side controller for the 8x12-bit register file.
// Buffers ALU and load results in order, drains one register write per cycle
// through registered rf_* outputs, and tracks per-register outstanding writes
// so decode can stall on RAW hazards.
//   clk, rst_n   clock, synchronous active-low reset
//   wb (slave)   mem_*/alu_* result handshakes, issue_*, chkN_sel/busyN,
//                fwdN_* operand forwarding, rf_we/rf_sel/rf_wdata write port
// Build option: define WB_BYPASS_EN to enable operand forwarding from the
// buffer and the in-flight rf_* write; otherwise fwdN_* are tied to zero.
// DATA_W/REG_AW come from cpu12_pkg because the buffered entry type is shared.
module reg_writeback
    import cpu12_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int PEND_W = WB_PEND_W
) (
    input logic            clk,
    input logic            rst_n,
    reg_writeback_if.slave wb
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]       count, free;
    logic                mem_push, alu_push, pop;
    wb_entry_t           head, mem_ent, alu_ent;
    logic                rf_we_q;
    logic [REG_AW-1:0]   rf_sel_q;
    logic [DATA_W-1:0]   rf_wdata_q;
    logic [NUM_REGS-1:0] pend_nz, pend_max;
`ifdef WB_BYPASS_EN
    wb_entry_t [DEPTH-1:0] ents;
    logic      [DEPTH-1:0] ents_vld;
`endif

    // Readies look at pre-pop occupancy only, so a slot freed by this
    // cycle's drain becomes usable next cycle.
    assign free         = CW'(DEPTH) - count;
    assign wb.mem_ready = (free >= CW'(1));
    assign wb.alu_ready = (free >= CW'(2));
    assign mem_push     = wb.mem_valid && wb.mem_ready;
    assign alu_push     = wb.alu_valid && wb.alu_ready;
    assign pop          = (count != '0);

    assign mem_ent.dst  = wb.mem_dst;
    assign mem_ent.data = wb.mem_data;
    assign alu_ent.dst  = wb.alu_dst;
    assign alu_ent.data = wb.alu_data;

    // Load result is the older of a simultaneous pair.
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (mem_push),
        .din_a   (mem_ent),
        .push_b  (alu_push),
        .din_b   (alu_ent),
        .pop     (pop),
        .head    (head),
        .count   (count)
`ifdef WB_BYPASS_EN
        ,
        .ents    (ents),
        .ents_vld(ents_vld)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_sel_q   <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= pop;
            if (pop) begin
                rf_sel_q   <= head.dst;
                rf_wdata_q <= head.data;
            end
        end
    end

    assign wb.rf_we    = rf_we_q;
    assign wb.rf_sel   = rf_sel_q;
    assign wb.rf_wdata = rf_wdata_q;

    // Pending counters: an entry stops being pending once it moves into rf_*.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
        logic              inc, dec;
        logic [PEND_W-1:0] cnt;

        assign inc = wb.issue_valid && (wb.issue_dst == REG_AW'(r));
        assign dec = pop && (head.dst == REG_AW'(r));

        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt <= '0;
            else if (inc && !dec && cnt != '1)
                cnt <= cnt + PEND_W'(1);
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - PEND_W'(1);
        end

        assign pend_nz[r]  = (cnt != '0);
        assign pend_max[r] = (cnt == '1);
    end

    assign wb.busy1 = pend_nz[wb.chk1_sel];
    assign wb.busy2 = pend_nz[wb.chk2_sel];

    a_pend_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wb.issue_valid && pend_max[wb.issue_dst] && !(pop && head.dst == wb.issue_dst)));

    a_pend_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !pend_nz[head.dst] && !(wb.issue_valid && wb.issue_dst == head.dst)));

`ifdef WB_BYPASS_EN
    // rf_* is the oldest candidate; later buffer entries override earlier ones.
    function automatic logic [DATA_W:0] lookup(input logic [REG_AW-1:0] sel);
        logic [DATA_W:0] res;
        res = '0;
        if (rf_we_q && rf_sel_q == sel) res = {1'b1, rf_wdata_q};
        for (int i = 0; i < DEPTH; i++)
            if (ents_vld[i] && ents[i].dst == sel) res = {1'b1, ents[i].data};
        return res;
    endfunction

    always_comb begin
        {wb.fwd1_hit, wb.fwd1_data} = lookup(wb.chk1_sel);
        {wb.fwd2_hit, wb.fwd2_data} = lookup(wb.chk2_sel);
    end
`else
    assign wb.fwd1_hit  = 1'b0;
    assign wb.fwd1_data = '0;
    assign wb.fwd2_hit  = 1'b0;
    assign wb.fwd2_data = '0;
`endif
endmodule
